// File: rtl/penalty_input_conditioner_if.sv
// Button/pulse bundle between the raw key inputs and the game FSM.
// master: drives the raw active-low keys and observes the conditioned pulses.
// slave : the conditioner itself (reads keys, drives pulses and defense).
interface penalty_input_conditioner_if;
  logic key_shoot_n;
  logic key_left_n;
  logic key_right_n;
  logic key_start_n;
  logic shoot;
  logic left;
  logic right;
  logic start;
  logic defense;

  modport master (
    output key_shoot_n, key_left_n, key_right_n, key_start_n,
    input  shoot, left, right, start, defense
  );

  modport slave (
    input  key_shoot_n, key_left_n, key_right_n, key_start_n,
    output shoot, left, right, start, defense
  );
endinterface

// File: rtl/penalty_input_conditioner.sv
// penalty_input_conditioner
// Front end of the penalty-shootout game: synchronizes and debounces the four
// active-low push-buttons into one-clock press pulses, keeps left/right
// mutually exclusive, and supplies a Galois-LFSR goalkeeper direction bit.
// Optional feature macro: AUTOREPEAT_EN (auto-repeat of held left/right).
// Button index order used internally: 0 shoot, 1 left, 2 right, 3 start.
module penalty_input_conditioner #(
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          REPEAT_CYCLES   = 8
) (
  input  logic                        clk,
  input  logic                        RST,
  penalty_input_conditioner_if.slave  bus
);

  localparam int          NB       = 4;
  localparam int          CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Reject nonsensical configurations at elaboration time.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("REPEAT_CYCLES must be at least 1");
    end
  endgenerate

  logic [NB-1:0] raw;       // active-high view of the raw keys
  logic [NB-1:0] stable;    // debounced levels (1 = pressed)
  logic [NB-1:0] stable_d;  // debounced levels one cycle late
  logic [NB-1:0] press;     // rising edge of the debounced level
  logic [1:0]    rep;       // auto-repeat events: [0] left, [1] right

  assign raw = ~{bus.key_start_n, bus.key_right_n, bus.key_left_n, bus.key_shoot_n};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CW-1:0]          cnt_reg;
      logic                   stable_reg;
      logic                   stable_d_reg;
      logic                   synced;

      assign synced = sync_reg[SYNC_STAGES-1];

      // Synchronizer chain for the asynchronous key.
      always_ff @(posedge clk) begin
        if (RST) sync_reg <= '0;
        else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
      end

      // Debouncer: flip the stable level only after DEBOUNCE_CYCLES disagreeing samples in a row.
      always_ff @(posedge clk) begin
        if (RST) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else if (synced == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_reg    <= '0;
          stable_reg <= ~stable_reg;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      // Delayed copy of the debounced level for press-edge detection.
      always_ff @(posedge clk) begin
        if (RST) stable_d_reg <= 1'b0;
        else     stable_d_reg <= stable_reg;
      end

      assign stable[gi]   = stable_reg;
      assign stable_d[gi] = stable_d_reg;
      assign press[gi]    = stable_reg & ~stable_d_reg;
    end
  endgenerate

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rep
      // gi 0 -> left (button 1, opposite 2); gi 1 -> right (button 2, opposite 1)
      localparam int SELF  = gi + 1;
      localparam int OTHER = 2 - gi;

      logic [RW-1:0] rep_cnt_reg;
      logic          held;
      logic          wrap;

      assign held = stable[SELF] & stable_d[SELF];
      assign wrap = (rep_cnt_reg == RW'(REPEAT_CYCLES - 1));
      // No repeats while the opposite direction is also held.
      assign rep[gi] = held & wrap & ~stable[OTHER];

      // Repeat period counter: restarts on each fresh press and stays cleared while released.
      always_ff @(posedge clk) begin
        if (RST || !stable[SELF] || press[SELF]) rep_cnt_reg <= '0;
        else if (wrap)                          rep_cnt_reg <= '0;
        else                                    rep_cnt_reg <= rep_cnt_reg + RW'(1);
      end
    end
  endgenerate
`else
  assign rep = 2'b00;
`endif

  logic left_evt;
  logic right_evt;
  logic shoot_reg;
  logic left_reg;
  logic right_reg;
  logic start_reg;
  logic [15:0] lfsr_reg;

  assign left_evt  = press[1] | rep[0];
  assign right_evt = press[2] | rep[1];

  // Output pulse registers; simultaneous left/right events cancel each other.
  always_ff @(posedge clk) begin
    if (RST) begin
      shoot_reg <= 1'b0;
      left_reg  <= 1'b0;
      right_reg <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      shoot_reg <= press[0];
      start_reg <= press[3];
      left_reg  <= left_evt & ~right_evt;
      right_reg <= right_evt & ~left_evt;
    end
  end

  // Right-shifting Galois LFSR, free-running outside reset; a zero seed is never loaded.
  always_ff @(posedge clk) begin
    if (RST) lfsr_reg <= SEED_EFF;
    else     lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);
  end

  assign bus.shoot   = shoot_reg;
  assign bus.left    = left_reg;
  assign bus.right   = right_reg;
  assign bus.start   = start_reg;
  assign bus.defense = lfsr_reg[0];

endmodule

// File: tb/tb_penalty_input_conditioner.sv
// Directed bench for penalty_input_conditioner (default parameters).
// Pulse timing is measured in clock-edge counts: a key changed just after
// edge N is first sampled on edge N+1 and its press pulse is high after edge N+7.
module tb_penalty_input_conditioner;

  logic clk = 1'b0;
  logic RST;

  always #5 clk = ~clk;

  penalty_input_conditioner_if bus_if ();

  penalty_input_conditioner dut (
    .clk (clk),
    .RST (RST),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Edge counter: value N after the N-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int shoot_cnt = 0, left_cnt = 0, right_cnt = 0, start_cnt = 0, both_hi = 0;
  int shoot_last = -1, left_last = -1, right_last = -1, start_last = -1;
  int right_times[$];

  always @(negedge clk) begin
    if (bus_if.shoot === 1'b1) begin
      shoot_cnt  <= shoot_cnt + 1;
      shoot_last <= cyc;
      $display("[%0d] shoot pulse", cyc);
    end
    if (bus_if.left === 1'b1) begin
      left_cnt  <= left_cnt + 1;
      left_last <= cyc;
      $display("[%0d] left pulse", cyc);
    end
    if (bus_if.right === 1'b1) begin
      right_cnt  <= right_cnt + 1;
      right_last <= cyc;
      right_times.push_back(cyc);
      $display("[%0d] right pulse", cyc);
    end
    if (bus_if.start === 1'b1) begin
      start_cnt  <= start_cnt + 1;
      start_last <= cyc;
      $display("[%0d] start pulse", cyc);
    end
    if (bus_if.left === 1'b1 && bus_if.right === 1'b1) both_hi <= both_hi + 1;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("check %s: %0d ok", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int def_seq[6] = '{1, 0, 0, 0, 0, 1};
  int t_key, t_rel, base_cnt, base_left, base_right, base_q;
  int exp_left_arb, exp_right_rep;

  initial begin
    bus_if.key_shoot_n = 1'b1;
    bus_if.key_left_n  = 1'b1;
    bus_if.key_right_n = 1'b1;
    bus_if.key_start_n = 1'b1;
    RST = 1'b1;

    // 1: reset state and LFSR start sequence ACE1,E270,7138,389C,1C4E,0E27
    tick(2);
    check_val("rst_shoot", int'(bus_if.shoot), 0);
    check_val("rst_left",  int'(bus_if.left),  0);
    check_val("rst_right", int'(bus_if.right), 0);
    check_val("rst_start", int'(bus_if.start), 0);
    check_val("defense_0", int'(bus_if.defense), def_seq[0]);
    RST = 1'b0;
    for (int i = 1; i < 6; i++) begin
      tick(1);
      check_val($sformatf("defense_%0d", i), int'(bus_if.defense), def_seq[i]);
    end
    tick(10);

    // 2: clean shoot press, 20 cycles, then release
    base_cnt = shoot_cnt;
    bus_if.key_shoot_n = 1'b0;
    t_key = cyc;
    tick(20);
    check_val("shoot_count", shoot_cnt - base_cnt, 1);
    check_val("shoot_time",  shoot_last, t_key + 7);
    bus_if.key_shoot_n = 1'b1;
    tick(20);
    check_val("shoot_release", shoot_cnt - base_cnt, 1);

    // 3: bounce 3 low / 1 high / 10 low -> one pulse from the final low run
    base_cnt = left_cnt;
    bus_if.key_left_n = 1'b0;
    tick(3);
    bus_if.key_left_n = 1'b1;
    tick(1);
    bus_if.key_left_n = 1'b0;
    t_key = cyc;
    tick(10);
    bus_if.key_left_n = 1'b1;
    tick(15);
    check_val("bounce_count", left_cnt - base_cnt, 1);
    check_val("bounce_time",  left_last, t_key + 7);
    // glitch of 3 samples alone
    base_cnt = left_cnt;
    bus_if.key_left_n = 1'b0;
    tick(3);
    bus_if.key_left_n = 1'b1;
    tick(15);
    check_val("glitch_count", left_cnt - base_cnt, 0);

    // 4a: left and right pressed on the same edge -> nothing
    base_left  = left_cnt;
    base_right = right_cnt;
    bus_if.key_left_n  = 1'b0;
    bus_if.key_right_n = 1'b0;
    tick(20);
    check_val("arb_same_left",  left_cnt - base_left, 0);
    check_val("arb_same_right", right_cnt - base_right, 0);
    bus_if.key_left_n  = 1'b1;
    bus_if.key_right_n = 1'b1;
    tick(20);

    // 4b: hold left, then press right -> right pulses once
    base_left  = left_cnt;
    base_right = right_cnt;
    bus_if.key_left_n = 1'b0;
    tick(10);
    bus_if.key_right_n = 1'b0;
    t_key = cyc;
    tick(15);
`ifdef AUTOREPEAT_EN
    // left alone for 8 cycles after its pulse gets one repeat before right becomes stable
    exp_left_arb = 2;
`else
    exp_left_arb = 1;
`endif
    check_val("arb_held_left",  left_cnt - base_left, exp_left_arb);
    check_val("arb_held_right", right_cnt - base_right, 1);
    check_val("arb_right_time", right_last, t_key + 7);
    bus_if.key_left_n  = 1'b1;
    bus_if.key_right_n = 1'b1;
    tick(20);
    check_val("arb_never_both", both_hi, 0);

    // 5: reset at debounce count 2 while start is held
    base_cnt = start_cnt;
    bus_if.key_start_n = 1'b0;
    tick(4);
    check_val("rstmid_before", start_cnt - base_cnt, 0);
    RST = 1'b1;
    tick(1);
    check_val("rstmid_defense", int'(bus_if.defense), 1);
    RST = 1'b0;
    t_rel = cyc;
    tick(15);
    check_val("rstmid_count", start_cnt - base_cnt, 1);
    check_val("rstmid_time",  start_last, t_rel + 7);
    bus_if.key_start_n = 1'b1;
    tick(15);

    // 6: right held 40 cycles; debounced release lands 46 edges after the press
    base_right = right_cnt;
    base_q     = right_times.size();
    bus_if.key_right_n = 1'b0;
    t_key = cyc;
    tick(40);
    bus_if.key_right_n = 1'b1;
    tick(20);
`ifdef AUTOREPEAT_EN
    exp_right_rep = 5;
`else
    exp_right_rep = 1;
`endif
    check_val("hold_count", right_cnt - base_right, exp_right_rep);
    for (int k = 0; k < exp_right_rep; k++) begin
      if (base_q + k < right_times.size())
        check_val($sformatf("hold_time_%0d", k), right_times[base_q + k], t_key + 7 + 8 * k);
      else
        check_val($sformatf("hold_missing_%0d", k), 0, 1);
    end
    check_val("final_never_both", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
